// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   PC_W        : program-counter width in bits
//   INSTR_W     : instruction word width in bits
//   fetch_pkt_t : one fetched packet as it travels from fetch to decode
package riscv_pkg;

    localparam int PC_W    = 48;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pred_pc;
        logic               pred_taken;
    } fetch_pkt_t;

endpackage : riscv_pkg

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling FIFO.
// Packets offered by fetch (valid_in/ready_out) are queued and presented to
// decode in push order (valid_out/ready_in). An EX-stage misprediction
// flushes every buffered packet at the next edge.
//
// Ports
//   clk, n_reset          : rising-edge clock, asynchronous active-low reset
//   valid_in, ready_out   : fetch-side handshake (ready_out = not full)
//   pc_in, instr_in,
//   pred_pc_in,
//   pred_taken_in         : fields of the offered packet
//   mispred_ex            : squash all entries, drop same-cycle push/pop
//   valid_out, ready_in   : decode-side handshake (valid_out = not empty)
//   pc_out, instr_out,
//   pred_pc_out,
//   pred_taken_out        : fields of the head packet
//   count                 : number of occupied entries, 0..DEPTH
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       valid_in,
    input  logic [PC_W-1:0]            pc_in,
    input  logic [INSTR_W-1:0]         instr_in,
    input  logic [PC_W-1:0]            pred_pc_in,
    input  logic                       pred_taken_in,
    output logic                       ready_out,
    input  logic                       mispred_ex,
    output logic                       valid_out,
    output logic [PC_W-1:0]            pc_out,
    output logic [INSTR_W-1:0]         instr_out,
    output logic [PC_W-1:0]            pred_pc_out,
    output logic                       pred_taken_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointers wrap by plain overflow, which only works for powers of two.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_buffer: DEPTH must be a power of two in 2..16");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    fetch_pkt_t mem_q [DEPTH];
    fetch_pkt_t wr_pkt;
    fetch_pkt_t head_pkt;

    logic push;
    logic pop;

    // Handshake status depends only on registered count, so neither ready
    // nor valid has a combinational path from the opposite side.
    assign ready_out = (count_q < CNT_W'(DEPTH));
    assign valid_out = (count_q != '0);
    assign count     = count_q;

    assign push = valid_in  && ready_out && !mispred_ex;
    assign pop  = valid_out && ready_in  && !mispred_ex;

    assign wr_pkt = '{pc:         pc_in,
                      instr:      instr_in,
                      pred_pc:    pred_pc_in,
                      pred_taken: pred_taken_in};

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (mispred_ex) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;  // idle, or push and pop together
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignment so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; count gates validity, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_pkt;
    end

    // Head comes straight from storage; a packet is visible the cycle after
    // it is written, never bypassed from the inputs.
    assign head_pkt       = mem_q[rd_ptr_q];
    assign pc_out         = head_pkt.pc;
    assign instr_out      = head_pkt.instr;
    assign pred_pc_out    = head_pkt.pred_pc;
    assign pred_taken_out = head_pkt.pred_taken;

endmodule : fetch_buffer
